// File: rtl/bar_leitor_ctrl.sv
// bar_leitor_ctrl: serial 2-of-5 barcode frame reader.
// Samples one bar bit per clock after a start request. Every five bits are
// decoded into a digit with weights 1,2,4,7,0. A frame ends after NSIMB good
// symbols or at the first bad symbol.
// Optional build macro: CHECKSUM_EN adds a modulo-10 digit-sum check at the
// end of each frame.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for PG; DEZ/ERRO keep the result of the last frame
// CAPT  | shifting in symbol bits, decoding each fifth bit
module bar_leitor_ctrl #(
    parameter int NSIMB = 10
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       PG,
    input  logic       I,
    output logic [3:0] DIGITO,
    output logic       DOIS,
    output logic       DEZ,
    output logic       FIM,
    output logic       ERRO
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CAPT  = 1'b1;
    localparam logic [2:0] LAST_BIT = 3'd4;
    localparam logic [3:0] LAST_SYM = 4'(NSIMB - 1);

    logic [0:0] state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] sym_cnt_q, sym_cnt_d;
    logic [3:0] sr_q, sr_d;
    logic [3:0] digito_q, digito_d;
    logic       dois_q, dois_d;
    logic       dez_q, dez_d;
    logic       fim_q, fim_d;
    logic       erro_q, erro_d;

    logic [2:0] ones;
    logic [4:0] wsum;
    logic [3:0] digit_dec;
    logic       sym_ok;
    logic       sym_edge;
    logic       sum_fail;

    // The fifth bit is never stored: it carries weight 0 and only counts
    // towards the number of ones, so it is taken straight from I.
    assign ones = {2'b00, sr_q[0]} + {2'b00, sr_q[1]} + {2'b00, sr_q[2]}
                + {2'b00, sr_q[3]} + {2'b00, I};
    assign wsum = (sr_q[0] ? 5'd1 : 5'd0) + (sr_q[1] ? 5'd2 : 5'd0)
                + (sr_q[2] ? 5'd4 : 5'd0) + (sr_q[3] ? 5'd7 : 5'd0);
    assign digit_dec = (wsum == 5'd11) ? 4'd0 : wsum[3:0];
    assign sym_ok    = (ones == 3'd2);
    assign sym_edge  = (state_q == ST_CAPT) && (bit_cnt_q == LAST_BIT);

`ifdef CHECKSUM_EN
    logic [3:0] sum_q, sum_d;
    logic [4:0] sum_add;
    logic [3:0] sum_next;

    assign sum_add  = {1'b0, sum_q} + {1'b0, digit_dec};
    assign sum_next = (sum_add >= 5'd10) ? 4'(sum_add - 5'd10) : sum_add[3:0];
    assign sum_fail = (sum_next != 4'd0);

    // Running digit sum, restarted on every accepted start request.
    always_comb begin
        sum_d = sum_q;
        if ((state_q == ST_IDLE) && PG) begin
            sum_d = 4'd0;
        end else if (sym_edge && sym_ok) begin
            sum_d = sum_next;
        end
    end

    // Digit-sum register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sum_q <= 4'd0;
        end else begin
            sum_q <= sum_d;
        end
    end
`else
    assign sum_fail = 1'b0;
`endif

    // Next-state and output decode for the capture sequencer.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sym_cnt_d = sym_cnt_q;
        sr_d      = sr_q;
        digito_d  = digito_q;
        dois_d    = 1'b0;
        fim_d     = 1'b0;
        dez_d     = dez_q;
        erro_d    = erro_q;
        case (state_q)
            ST_IDLE: begin
                if (PG) begin
                    state_d   = ST_CAPT;
                    bit_cnt_d = 3'd0;
                    sym_cnt_d = 4'd0;
                    sr_d      = 4'd0;
                    dez_d     = 1'b0;
                    erro_d    = 1'b0;
                end
            end
            ST_CAPT: begin
                if (bit_cnt_q != LAST_BIT) begin
                    // First bit enters at the top and ends up in sr_q[0].
                    sr_d      = {I, sr_q[3:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end else begin
                    bit_cnt_d = 3'd0;
                    sr_d      = 4'd0;
                    if (!sym_ok) begin
                        erro_d  = 1'b1;
                        fim_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        digito_d = digit_dec;
                        dois_d   = 1'b1;
                        if (sym_cnt_q == LAST_SYM) begin
                            fim_d   = 1'b1;
                            dez_d   = 1'b1;
                            erro_d  = sum_fail;
                            state_d = ST_IDLE;
                        end else begin
                            sym_cnt_d = sym_cnt_q + 4'd1;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 3'd0;
            sym_cnt_q <= 4'd0;
            sr_q      <= 4'd0;
            digito_q  <= 4'd0;
            dois_q    <= 1'b0;
            dez_q     <= 1'b0;
            fim_q     <= 1'b0;
            erro_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            sym_cnt_q <= sym_cnt_d;
            sr_q      <= sr_d;
            digito_q  <= digito_d;
            dois_q    <= dois_d;
            dez_q     <= dez_d;
            fim_q     <= fim_d;
            erro_q    <= erro_d;
        end
    end

    assign DIGITO = digito_q;
    assign DOIS   = dois_q;
    assign DEZ    = dez_q;
    assign FIM    = fim_q;
    assign ERRO   = erro_q;

endmodule

// File: tb/tb_bar_leitor_ctrl.sv
// Directed bench for bar_leitor_ctrl: one instance with NSIMB=10 and one with
// NSIMB=2. Outputs are compared as a packed vector {DIGITO,DOIS,DEZ,FIM,ERRO}.
module tb_bar_leitor_ctrl;

`ifdef CHECKSUM_EN
    localparam logic CK = 1'b1;
`else
    localparam logic CK = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST_N;
    logic pg_drv, i_drv, sel;
    logic pg1, i1, pg2, i2;
    logic [3:0] digito1, digito2;
    logic dois1, dez1, fim1, erro1;
    logic dois2, dez2, fim2, erro2;
    logic [7:0] o_vec;

    int n_chk = 0;
    int n_pass = 0;
    int edge_n = 0;
    int pg_at_a = -1;
    int pg_at_b = -1;
    logic pg_hold = 1'b0;
    logic [3:0] exp_dig = 4'd0;

    logic [4:0] e_code [10] = '{5'b10001, 5'b10010, 5'b00011, 5'b10100, 5'b01100,
                                5'b01100, 5'b01100, 5'b01100, 5'b01100, 5'b01100};
    logic [3:0] e_dig  [10] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0,
                                4'd0, 4'd0, 4'd0, 4'd0, 4'd0};

    assign pg1 = sel ? 1'b0 : pg_drv;
    assign i1  = sel ? 1'b0 : i_drv;
    assign pg2 = sel ? pg_drv : 1'b0;
    assign i2  = sel ? i_drv : 1'b0;
    assign o_vec = sel ? {digito2, dois2, dez2, fim2, erro2}
                       : {digito1, dois1, dez1, fim1, erro1};

    bar_leitor_ctrl #(.NSIMB(10)) u_dut (
        .CLK(CLK), .RST_N(RST_N), .PG(pg1), .I(i1),
        .DIGITO(digito1), .DOIS(dois1), .DEZ(dez1), .FIM(fim1), .ERRO(erro1)
    );

    bar_leitor_ctrl #(.NSIMB(2)) u_dut2 (
        .CLK(CLK), .RST_N(RST_N), .PG(pg2), .I(i2),
        .DIGITO(digito2), .DOIS(dois2), .DEZ(dez2), .FIM(fim2), .ERRO(erro2)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] ov(input logic [3:0] d, input logic dois,
                                      input logic dez, input logic fim, input logic erro);
        return {d, dois, dez, fim, erro};
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b ({digito,dois,dez,fim,erro})", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
        edge_n++;
    endtask

    task automatic start_frame;
        pg_drv = 1'b1;
        @(posedge CLK);
        #1;
        edge_n = 0;
        pg_drv = pg_hold;
    endtask

    // Drives five bits (b[0] first), checks quiet outputs between bits and
    // exp_end right after the fifth bit edge.
    task automatic send_sym(input logic [4:0] b, input logic [7:0] exp_end, input string tag);
        for (int i = 0; i < 5; i++) begin
            i_drv  = b[i];
            pg_drv = pg_hold || ((edge_n + 1) == pg_at_a) || ((edge_n + 1) == pg_at_b);
            tick();
            if (i < 4) check({tag, " mid"}, o_vec, ov(exp_dig, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        check({tag, " end"}, o_vec, exp_end);
        exp_dig = exp_end[7:4];
        pg_drv  = pg_hold;
        i_drv   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        sel = 1'b0; pg_drv = 1'b0; i_drv = 1'b0; RST_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset dut1", o_vec, 8'h00);
        sel = 1'b1;
        #1;
        check("reset dut2", o_vec, 8'h00);
        sel = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        tick();
        check("idle no pg", o_vec, 8'h00);

        // ten digit-0 symbols
        start_frame();
        check("A start", o_vec, ov(4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        for (int s = 0; s < 10; s++)
            send_sym(5'b01100, ov(4'd0, 1'b1, s == 9, s == 9, 1'b0), "A sym");
        tick();
        check("A after", o_vec, ov(4'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        tick();
        check("A hold", o_vec, ov(4'd0, 1'b0, 1'b1, 1'b0, 1'b0));

        // 3, 7, then a bad symbol
        start_frame();
        check("B start dez clr", o_vec, ov(4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        send_sym(5'b00011, ov(4'd3, 1'b1, 1'b0, 1'b0, 1'b0), "B s1");
        send_sym(5'b11000, ov(4'd7, 1'b1, 1'b0, 1'b0, 1'b0), "B s2");
        send_sym(5'b00111, ov(4'd7, 1'b0, 1'b0, 1'b1, 1'b1), "B s3 bad");
        tick();
        check("B hold erro", o_vec, ov(4'd7, 1'b0, 1'b0, 1'b0, 1'b1));

        // digit 3 then nine digit 0: checksum 3
        start_frame();
        check("C start erro clr", o_vec, ov(4'd7, 1'b0, 1'b0, 1'b0, 1'b0));
        send_sym(5'b00011, ov(4'd3, 1'b1, 1'b0, 1'b0, 1'b0), "C s1");
        for (int s = 1; s < 10; s++)
            send_sym(5'b01100, ov(4'd0, 1'b1, s == 9, s == 9, (s == 9) && CK), "C sym");
        tick();
        check("C hold", o_vec, ov(4'd0, 1'b0, 1'b1, 1'b0, CK));

        // reset at edge 23 mid-frame
        start_frame();
        check("D start", o_vec, ov(4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        for (int s = 0; s < 4; s++)
            send_sym(5'b00101, ov(4'd5, 1'b1, 1'b0, 1'b0, 1'b0), "D sym");
        for (int i = 0; i < 3; i++) begin
            i_drv = 1'b1;
            tick();
            check("D partial", o_vec, ov(4'd5, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        i_drv = 1'b0;
        #2 RST_N = 1'b0;
        #1;
        check("D async reset", o_vec, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("D reset no fim", o_vec, 8'h00);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        exp_dig = 4'd0;

        // clean frame after reset, PG pulses at edges 7 and 30
        start_frame();
        pg_at_a = 7;
        pg_at_b = 30;
        for (int s = 0; s < 10; s++)
            send_sym(e_code[s], ov(e_dig[s], 1'b1, s == 9, s == 9, 1'b0), "E sym");
        pg_at_a = -1;
        pg_at_b = -1;
        tick();
        check("E after", o_vec, ov(4'd0, 1'b0, 1'b1, 1'b0, 1'b0));

        // PG held high: ignored in capture, restarts on first idle edge
        pg_hold = 1'b1;
        start_frame();
        for (int s = 0; s < 10; s++)
            send_sym(5'b01100, ov(4'd0, 1'b1, s == 9, s == 9, 1'b0), "F sym");
        tick();
        check("F restart edge51", o_vec, ov(4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        pg_hold = 1'b0;
        pg_drv  = 1'b0;
        edge_n  = 0;
        send_sym(5'b11000, ov(4'd7, 1'b1, 1'b0, 1'b0, 1'b0), "F new s1");
        RST_N = 1'b0;
        #2;
        check("F reset", o_vec, 8'h00);
        @(negedge CLK);
        RST_N = 1'b1;
        exp_dig = 4'd0;

        // NSIMB=2 instance, two digit-5 symbols
        sel = 1'b1;
        start_frame();
        check("G start", o_vec, 8'h00);
        send_sym(5'b00101, ov(4'd5, 1'b1, 1'b0, 1'b0, 1'b0), "G s1");
        send_sym(5'b00101, ov(4'd5, 1'b1, 1'b1, 1'b1, 1'b0), "G s2");
        tick();
        check("G after", o_vec, ov(4'd5, 1'b0, 1'b1, 1'b0, 1'b0));
        sel = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
